// File: rtl/index_mask_builder.sv
// Streams bit indices in, ORs their one-hot decode into a mask, and hands the
// finished mask out (with distinct-bit count, duplicate and range-error flags) on in_last.
module index_mask_builder #(
    parameter int WIDTH = 16,
    parameter int IDXW  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDXW-1:0]   in_idx,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_mask,
    output logic [IDXW:0]     out_count,
    output logic              out_dup,
    output logic              out_err
);

    localparam logic [IDXW:0] WIDTH_C = (IDXW+1)'(WIDTH);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  mask_q, mask_d;
    logic [IDXW:0]     count_q, count_d;
    logic              dup_q, dup_d;
    logic              err_q, err_d;

    logic              in_fire;
    logic              out_fire;
    logic              idx_ok;
    logic              bit_set;
    logic [WIDTH-1:0]  onehot;

    // Count is one bit wider than the index so a full mask (count == WIDTH) fits.
    function automatic logic [IDXW:0] sat_inc(input logic [IDXW:0] c);
        return (c >= WIDTH_C) ? c : c + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCUM;
            mask_q  <= '0;
            count_q <= '0;
            dup_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            dup_q   <= dup_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (in_fire && in_last) state_d = HOLD;
            HOLD:    if (out_fire)           state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // Handshake outputs depend on state only, so ready never follows out_ready.
    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == HOLD);
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign idx_ok   = ({1'b0, in_idx} < WIDTH_C);
    assign onehot   = idx_ok ? (WIDTH'(1) << in_idx) : '0;
    assign bit_set  = |(mask_q & onehot);

    always_comb begin
        mask_d  = mask_q;
        count_d = count_q;
        dup_d   = dup_q;
        err_d   = err_q;
        if (out_fire) begin
            mask_d  = '0;
            count_d = '0;
            dup_d   = 1'b0;
            err_d   = 1'b0;
        end else if (in_fire) begin
            if (!idx_ok) begin
                err_d = 1'b1;
            end else if (bit_set) begin
                dup_d = 1'b1;
            end else begin
                mask_d  = mask_q | onehot;
                count_d = sat_inc(count_q);
            end
        end
    end

    assign out_mask  = mask_q;
    assign out_count = count_q;
    assign out_dup   = dup_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_index_mask_builder.sv
// Drives one index stream into a 16-bit and a 12-bit instance side by side and
// compares both against a behavioural accumulator and a queue of finished frames.
module tb_index_mask_builder;

    typedef struct packed {
        logic [15:0] mask;
        logic [4:0]  count;
        logic        dup;
        logic        err;
    } res_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [3:0]  in_idx;
    logic        in_last;
    logic        out_ready;

    logic        rdy16, vld16, dup16, err16;
    logic [15:0] mask16;
    logic [4:0]  cnt16;
    logic        rdy12, vld12, dup12, err12;
    logic [11:0] mask12;
    logic [4:0]  cnt12;

    int   n_checks = 0;
    int   n_pass   = 0;

    res_t acc16, acc12;
    logic hold;
    res_t q16[$];
    res_t q12[$];

    always #5 clk = ~clk;

    index_mask_builder #(.WIDTH(16), .IDXW(4)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy16),
        .in_idx(in_idx), .in_last(in_last), .out_valid(vld16), .out_ready(out_ready),
        .out_mask(mask16), .out_count(cnt16), .out_dup(dup16), .out_err(err16)
    );

    index_mask_builder #(.WIDTH(12), .IDXW(4)) dut12 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy12),
        .in_idx(in_idx), .in_last(in_last), .out_valid(vld12), .out_ready(out_ready),
        .out_mask(mask12), .out_count(cnt12), .out_dup(dup12), .out_err(err12)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic res_t apply(input res_t r, input int w, input int idx);
        res_t n = r;
        if (idx >= w)          n.err = 1'b1;
        else if (r.mask[idx])  n.dup = 1'b1;
        else begin
            n.mask[idx] = 1'b1;
            n.count     = r.count + 5'd1;
        end
        return n;
    endfunction

    task automatic check_dut(input string nm, input logic rdy, input logic vld,
                             input logic [15:0] gm, input logic [4:0] gc,
                             input logic gd, input logic ge, input res_t e);
        check({nm, ".in_ready"},  {31'd0, rdy}, {31'd0, !hold});
        check({nm, ".out_valid"}, {31'd0, vld}, {31'd0, hold});
        check({nm, ".mask"},  {16'd0, gm}, {16'd0, e.mask});
        check({nm, ".count"}, {27'd0, gc}, {27'd0, e.count});
        check({nm, ".dup"},   {31'd0, gd}, {31'd0, e.dup});
        check({nm, ".err"},   {31'd0, ge}, {31'd0, e.err});
    endtask

    // One clock: drive inputs, check at negedge, advance the model after the edge.
    task automatic cycle(input logic v, input logic [3:0] idx, input logic last, input logic ordy);
        res_t e16, e12;
        in_valid = v; in_idx = idx; in_last = last; out_ready = ordy;
        @(negedge clk);
        e16 = acc16;
        e12 = acc12;
        if (hold) begin
            if (q16.size() == 0 || q12.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
            else begin
                e16 = q16[0];
                e12 = q12[0];
            end
        end
        check_dut("w16", rdy16, vld16, mask16, cnt16, dup16, err16, e16);
        check_dut("w12", rdy12, vld12, {4'd0, mask12}, cnt12, dup12, err12, e12);
        @(posedge clk);
        #1;
        if (!hold && v) begin
            acc16 = apply(acc16, 16, int'(idx));
            acc12 = apply(acc12, 12, int'(idx));
            if (last) begin
                q16.push_back(acc16);
                q12.push_back(acc12);
                hold = 1'b1;
            end
        end else if (hold && ordy) begin
            if (q16.size() != 0) void'(q16.pop_front());
            if (q12.size() != 0) void'(q12.pop_front());
            acc16 = '0;
            acc12 = '0;
            hold  = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_idx = '0; in_last = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        acc16 = '0; acc12 = '0; hold = 1'b0;
        q16.delete(); q12.delete();
    endtask

    initial begin
        do_reset();
        cycle(0, 4'd0, 0, 1);

        // basic frame, consumer always ready
        cycle(1, 4'd1, 0, 1); cycle(1, 4'd3, 0, 1); cycle(1, 4'd4, 0, 1); cycle(1, 4'd5, 1, 1);
        cycle(0, 4'd0, 0, 1); cycle(0, 4'd0, 0, 1);

        // duplicate, then a clean frame back to back
        cycle(1, 4'd0, 0, 1); cycle(1, 4'd5, 0, 1); cycle(1, 4'd5, 0, 1); cycle(1, 4'd6, 1, 1);
        cycle(1, 4'd9, 0, 1);
        cycle(1, 4'd0, 0, 1); cycle(1, 4'd3, 0, 1); cycle(1, 4'd5, 0, 1); cycle(1, 4'd6, 1, 1);
        cycle(0, 4'd0, 0, 1);

        // single-beat frame, then a full mask
        cycle(1, 4'd1, 1, 1); cycle(0, 4'd0, 0, 1);
        for (int i = 15; i >= 0; i--) cycle(1, 4'(i), (i == 0), 1);
        cycle(0, 4'd0, 0, 1);

        // backpressure: beats offered while holding must be ignored
        cycle(1, 4'd1, 0, 0); cycle(1, 4'd3, 0, 0); cycle(1, 4'd4, 0, 0); cycle(1, 4'd5, 1, 0);
        for (int i = 0; i < 5; i++) cycle(1, 4'd7, (i == 2), 0);
        cycle(0, 4'd0, 0, 1);
        cycle(1, 4'd2, 1, 1); cycle(0, 4'd0, 0, 1);

        // out-of-range index for the 12-bit instance
        cycle(1, 4'd13, 0, 1); cycle(1, 4'd2, 1, 1); cycle(0, 4'd0, 0, 1);
        cycle(1, 4'd15, 1, 1); cycle(0, 4'd0, 0, 1);

        // reset mid-frame and in HOLD discards the frame
        cycle(1, 4'd1, 0, 1); cycle(1, 4'd3, 0, 1);
        do_reset();
        cycle(0, 4'd0, 0, 1);
        cycle(1, 4'd6, 1, 1); cycle(0, 4'd0, 0, 1);
        cycle(1, 4'd8, 1, 0); cycle(0, 4'd0, 0, 0);
        do_reset();
        cycle(0, 4'd0, 0, 0);

        // random frames with random backpressure
        for (int f = 0; f < 20; f++) begin
            int len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++)
                cycle(1'($urandom_range(0, 1) | (b == len - 1)), 4'($urandom_range(0, 15)),
                      (b == len - 1), 1'($urandom_range(0, 1)));
            for (int k = 0; k < 3; k++) cycle(0, 4'd0, 0, 1'($urandom_range(0, 1)));
            cycle(0, 4'd0, 0, 1);
            cycle(0, 4'd0, 0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/index_mask_builder.md
# index_mask_builder

Sequential index-to-mask decoder: accepts a stream of bit indices over a valid/ready handshake, decodes each into a one-hot word, and ORs it into an accumulating mask. The mask is emitted on a second valid/ready handshake when a beat flagged `in_last` is accepted. It sits upstream of the first-set-bit priority encoder: the encoder turns a mask into the index of its lowest set bit, and this block builds masks from indices. Per-frame duplicate count and error flags are reported.

## Interface
Parameters:
- `WIDTH`, 16, mask width in bits.
- `IDXW`, 4, index width; must be at least $clog2(WIDTH).

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  index beat present.
- `in_ready`  out  1  block can accept an index beat.
- `in_idx`  in  IDXW  bit index to set.
- `in_last`  in  1  beat closes the current frame.
- `out_valid`  out  1  completed mask available.
- `out_ready`  in  1  consumer takes the mask.
- `out_mask`  out  WIDTH  accumulated mask.
- `out_count`  out  IDXW+1  number of distinct bits set in `out_mask`.
- `out_dup`  out  1  at least one index in the frame was already set.
- `out_err`  out  1  at least one index in the frame was `>= WIDTH`.

## Operation
- Two states: ACCUM and HOLD. Reset enters ACCUM.
- Reset values: mask = 0, count = 0, dup = 0, err = 0, `out_valid` = 0, `in_ready` = 1.
- ACCUM:
  - `in_ready` = 1 and `out_valid` = 0.
  - A beat is accepted when `in_valid & in_ready` is high on a clock edge.
- Accepted beat with `in_idx < WIDTH`:
  - If mask bit `in_idx` is already 1, set dup sticky. Count and mask do not change.
  - Otherwise set the bit and increment count.
- Accepted beat with `in_idx >= WIDTH`:
  - Set err sticky. Mask and count do not change.
  - The frame still closes normally if `in_last` is set.
- Accepted beat with `in_last` = 1: the bit update above applies, then the state goes to HOLD.
- HOLD:
  - `in_ready` = 0 and `out_valid` = 1.
  - `out_mask`, `out_count`, `out_dup` and `out_err` are held stable until the handshake.
- When `out_valid & out_ready` is high on an edge:
  - Clear mask, count, dup and err.
  - Return to ACCUM.
- Outputs always drive the registered accumulator. In ACCUM they show the partial frame, which is not qualified by `out_valid`.
- Count width is IDXW+1 so that count = WIDTH is representable, e.g. 16 fits in 5 bits. Count never exceeds WIDTH.
- Reset has priority over every event. Reset in mid-frame or in HOLD discards the frame with no output handshake.

## Timing
- Input acceptance: one beat per cycle, zero bubbles, while in ACCUM.
- Latency: `out_valid` rises on the edge that accepts the `in_last` beat. The mask is visible one cycle after that beat is presented. It includes the last beat's bit.
- Handshake rules:
  - `out_valid` stays high until `out_ready` is seen. A consumer may hold `out_ready` high permanently.
  - `in_ready` is deasserted combinationally from state only. It has no dependency on `out_ready`, so there is no combinational in-to-out path.
- Turnaround: HOLD lasts at least 1 cycle. The first beat of the next frame can be accepted on the cycle after the output handshake.
- A single-beat frame (first beat has `in_last` = 1) is legal and takes 2 cycles minimum per frame.
- `in_idx` and `in_last` are ignored when `in_valid` = 0 or the block is in HOLD.

## Test plan
- Indices 1, 3, 4, 5 (last on 5), `out_ready` = 1 -> `out_mask` = 0x003A, count 4, dup 0, err 0. `out_valid` is high for exactly 1 cycle.
- Indices 0, 5, 5, 6 (last on 6) -> `out_mask` = 0x0061, count 3, dup 1. Next frame 0, 3, 5, 6 -> 0x0069, count 4, dup 0, so the flags cleared between frames.
- Single beat idx 1 with last -> 0x0002, count 1. All 16 indices 15..0 -> 0xFFFF, count 16 (5'b10000).
- Backpressure: frame 1, 3, 4, 5 with `out_ready` = 0 for 5 cycles -> `out_valid` is held, `in_ready` = 0, and beats offered during HOLD are not absorbed. The mask stays 0x003A until `out_ready`, and the next frame then starts clean.
- With `WIDTH` = 12: idx 13 then idx 2 (last) -> `out_mask` = 0x004, count 1, err 1.
- Reset asserted after indices 1 and 3 of a frame -> all outputs return to reset values. A following frame with idx 6 (last) -> 0x0040, count 1.
